channel_event_decoder: RTL and testbench
========================================

CHANNEL_EVENT_DECODER -- requirements
Module: channel_event_decoder

Interface
REQ-001 Parameter N_CH, default 16: channel count; power of two, at least 2.
REQ-002 Parameter TIMEOUT, default 255: idle cycles allowed in COLLECT before abort; at least 1.
REQ-003 There SHALL be one clock and a synchronous, active-high reset, ports named clk_i and reset_i.
REQ-004 clk_i  in  1  sole clock; all state updates on the rising edge.
REQ-005 reset_i  in  1  synchronous active-high reset.
REQ-006 arm_i  in  1  frame-start pulse from the channel encoder.
REQ-007 dump_i  in  1  beat strobe; one channel beat per high cycle.
REQ-008 ch_sel_i  in  N_CH  one-hot channel of the beat; all-zero with dump_i marks end of frame.
REQ-009 frame_ready_i  in  1  consumer accepts frame_o.
REQ-010 clr_i  in  1  clears err_sticky_o.
REQ-011 frame_o  out  N_CH  reconstructed channel mask.
REQ-012 count_o  out  $clog2(N_CH)+1  number of distinct channels in frame_o.
REQ-013 frame_valid_o  out  1  frame_o and count_o are valid.
REQ-014 err_o  out  5  one-cycle error pulses, bits: [0] onehot, [1] order, [2] overflow, [3] abort, [4] timeout.
REQ-015 err_sticky_o  out  5  OR-accumulated err_o.

Function
REQ-016 The FSM SHALL have two states: IDLE and COLLECT.
REQ-017 IDLE, arm_i: go to COLLECT; clear accumulator, distinct-count, previous-index register and timeout counter.
REQ-018 IDLE, dump_i without arm_i: beat ignored, no error, state unchanged.
REQ-019 COLLECT, arm_i: pulse err_o[3], discard the partial frame, restart as in REQ-017; arm_i has priority over a simultaneous dump_i.
REQ-020 COLLECT, dump_i with exactly one bit of ch_sel_i set at index k: OR bit k into the accumulator; increment the count only if bit k was previously clear.
REQ-021 Under REQ-020, if an earlier beat exists in the frame and k is not above the previous index, pulse err_o[1]; the bit is still accumulated and the previous index becomes k.
REQ-022 COLLECT, dump_i with two or more bits set: pulse err_o[0], discard the beat, leave the previous index unchanged.
REQ-023 COLLECT, dump_i with ch_sel_i zero: terminate the frame and go to IDLE.
REQ-024 At termination, if the output slot is free (frame_valid_o low, or frame_ready_i high this cycle), load frame_o and count_o and assert frame_valid_o on the next cycle (latency 1).
REQ-025 At termination with the slot occupied and frame_ready_i low: drop the new frame, pulse err_o[2], keep the held frame unchanged.
REQ-026 An empty frame (arm_i then terminator) SHALL be delivered as frame_o 0 with count_o 0.
REQ-027 frame_valid_o, once asserted, holds with frame_o and count_o stable until a cycle with frame_ready_i high; it then drops unless a reload occurs in that same cycle.
REQ-028 The timeout counter increments on each COLLECT cycle without dump_i and clears on any dump_i.
REQ-029 When the timeout counter reaches TIMEOUT: pulse err_o[4], discard the partial frame, go to IDLE.
REQ-030 err_sticky_o SHALL be ORed with err_o every cycle; clr_i clears it, and a same-cycle new error wins.

Reset
REQ-031 While reset_i is high: state IDLE, frame_o 0, count_o 0, frame_valid_o 0, err_o 0, err_sticky_o 0, all internal counters 0.
REQ-032 Reset mid-COLLECT or with a frame pending discards everything without any error pulse.

Structure
REQ-033 State enum, err_o bit-index constants and the default N_CH SHALL live in shared package ergene_pkg.
REQ-034 One-hot-to-index conversion SHALL be sub-module onehot_dec, outputs: index, single, multi.

Verification (N_CH=16, TIMEOUT=255)
REQ-035 arm; dumps 0x0002, 0x0010, 0x8000; dump 0x0000 -> next cycle frame_valid_o=1, frame_o=0x8012, count_o=3, err_o=0 throughout.
REQ-036 arm; dump 0x0030; dump 0x0004; terminate -> err_o[0] pulse on beat 1, frame_o=0x0004, count_o=1.
REQ-037 arm; dump 0x0010, 0x0004, 0x0004; terminate -> err_o[1] pulses twice, frame_o=0x0014, count_o=2.
REQ-038 frame 0x0001 pending, frame_ready_i=0; second frame 0x0100 terminates -> err_o[2] pulse, frame_o stays 0x0001; ready high -> valid drops.
REQ-039 arm; 255 cycles without dump_i -> err_o[4] pulse, IDLE, no frame_valid_o; following arm/terminate delivers an empty frame.
REQ-040 arm; dump 0x0008; reset_i for 1 cycle -> all outputs 0, no error pulse; later clr_i clears err_sticky_o.

Source files
------------

// File: rtl/ergene_pkg.sv
// Shared types and constants for the channel event decoder.
package ergene_pkg;

   localparam int unsigned DefaultNCh = 16;
   localparam int unsigned NumErr     = 5;

   // Bit positions within err_o / err_sticky_o.
   localparam int unsigned ErrOnehot   = 0;
   localparam int unsigned ErrOrder    = 1;
   localparam int unsigned ErrOverflow = 2;
   localparam int unsigned ErrAbort    = 3;
   localparam int unsigned ErrTimeout  = 4;

   typedef enum logic {
      StIdle,
      StCollect
   } state_e;

endpackage

// File: rtl/onehot_dec.sv
// One-hot to binary index; flags exactly-one and two-or-more bits set.
module onehot_dec #(
   parameter  int unsigned N  = 16,
   localparam int unsigned IW = $clog2(N)
) (
   input  logic [N-1:0]  sel_i,
   output logic [IW-1:0] index_o,
   output logic          single_o,
   output logic          multi_o
);

   // OR of set-bit indices; only meaningful when single_o is high.
   always_comb begin
      index_o = '0;
      for (int unsigned i = 0; i < N; i++) begin
         if (sel_i[i]) index_o = index_o | IW'(i);
      end
   end

   assign multi_o  = |(sel_i & (sel_i - N'(1)));
   assign single_o = (|sel_i) && !multi_o;

endmodule

// File: rtl/channel_event_decoder.sv
// Rebuilds a channel mask from a stream of one-hot beats framed by arm/terminator,
// with error reporting and a single-entry output slot.
module channel_event_decoder
   import ergene_pkg::*;
#(
   parameter int unsigned N_CH    = DefaultNCh,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic                    clk_i,
   input  logic                    reset_i,
   input  logic                    arm_i,
   input  logic                    dump_i,
   input  logic [N_CH-1:0]         ch_sel_i,
   input  logic                    frame_ready_i,
   input  logic                    clr_i,
   output logic [N_CH-1:0]         frame_o,
   output logic [$clog2(N_CH):0]   count_o,
   output logic                    frame_valid_o,
   output logic [NumErr-1:0]       err_o,
   output logic [NumErr-1:0]       err_sticky_o
);

   localparam int unsigned IW = $clog2(N_CH);
   localparam int unsigned CW = IW + 1;
   localparam int unsigned TW = $clog2(TIMEOUT + 1);

   state_e            state_q, state_d;
   logic [N_CH-1:0]   acc_q, acc_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [IW-1:0]     prev_q, prev_d;
   logic              have_prev_q, have_prev_d;
   logic [TW-1:0]     tmo_q, tmo_d;
   logic [N_CH-1:0]   frame_q, frame_d;
   logic [CW-1:0]     count_q, count_d;
   logic              valid_q, valid_d;
   logic [NumErr-1:0] err_q, err_d;
   logic [NumErr-1:0] sticky_q, sticky_d;

   logic [IW-1:0] dec_idx;
   logic          dec_single;
   logic          dec_multi;
   logic          slot_free;

   onehot_dec #(
      .N (N_CH)
   ) u_onehot_dec (
      .sel_i    (ch_sel_i),
      .index_o  (dec_idx),
      .single_o (dec_single),
      .multi_o  (dec_multi)
   );

   assign slot_free = !valid_q || frame_ready_i;

   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      prev_d      = prev_q;
      have_prev_d = have_prev_q;
      tmo_d       = tmo_q;
      frame_d     = frame_q;
      count_d     = count_q;
      valid_d     = valid_q && !frame_ready_i;
      err_d       = '0;

      unique case (state_q)
         StIdle: begin
            if (arm_i) begin
               state_d     = StCollect;
               acc_d       = '0;
               cnt_d       = '0;
               prev_d      = '0;
               have_prev_d = 1'b0;
               tmo_d       = '0;
            end
         end
         StCollect: begin
            if (arm_i) begin
               err_d[ErrAbort] = 1'b1;
               acc_d           = '0;
               cnt_d           = '0;
               prev_d          = '0;
               have_prev_d     = 1'b0;
               tmo_d           = '0;
            end else if (dump_i) begin
               tmo_d = '0;
               if (dec_single) begin
                  if (have_prev_q && (dec_idx <= prev_q)) err_d[ErrOrder] = 1'b1;
                  if (!acc_q[dec_idx]) cnt_d = cnt_q + CW'(1);
                  acc_d       = acc_q | ch_sel_i;
                  prev_d      = dec_idx;
                  have_prev_d = 1'b1;
               end else if (dec_multi) begin
                  err_d[ErrOnehot] = 1'b1;
               end else begin
                  state_d = StIdle;
                  if (slot_free) begin
                     frame_d = acc_q;
                     count_d = cnt_q;
                     valid_d = 1'b1;
                  end else begin
                     err_d[ErrOverflow] = 1'b1;
                  end
               end
            end else begin
               tmo_d = tmo_q + TW'(1);
               if (tmo_d == TW'(TIMEOUT)) begin
                  err_d[ErrTimeout] = 1'b1;
                  state_d           = StIdle;
               end
            end
         end
         default: state_d = StIdle;
      endcase

      // A fresh error in the clearing cycle still sticks.
      sticky_d = (clr_i ? '0 : sticky_q) | err_d;
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q     <= StIdle;
         acc_q       <= '0;
         cnt_q       <= '0;
         prev_q      <= '0;
         have_prev_q <= 1'b0;
         tmo_q       <= '0;
         frame_q     <= '0;
         count_q     <= '0;
         valid_q     <= 1'b0;
         err_q       <= '0;
         sticky_q    <= '0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         prev_q      <= prev_d;
         have_prev_q <= have_prev_d;
         tmo_q       <= tmo_d;
         frame_q     <= frame_d;
         count_q     <= count_d;
         valid_q     <= valid_d;
         err_q       <= err_d;
         sticky_q    <= sticky_d;
      end
   end

   assign frame_o       = frame_q;
   assign count_o       = count_q;
   assign frame_valid_o = valid_q;
   assign err_o         = err_q;
   assign err_sticky_o  = sticky_q;

endmodule

// File: tb/tb_channel_event_decoder.sv
// Scoreboard bench: stimulus queues expected frames/error pulses, a monitor pops and compares.
module tb_channel_event_decoder;

   localparam int unsigned N_CH = 16;

   typedef struct packed {
      logic [15:0] frame;
      logic [4:0]  count;
   } frm_t;

   logic        clk_i = 1'b0;
   logic        reset_i = 1'b1;
   logic        arm_i = 1'b0;
   logic        dump_i = 1'b0;
   logic [15:0] ch_sel_i = '0;
   logic        frame_ready_i = 1'b1;
   logic        clr_i = 1'b0;
   logic [15:0] frame_o;
   logic [4:0]  count_o;
   logic        frame_valid_o;
   logic [4:0]  err_o;
   logic [4:0]  err_sticky_o;

   int   n_chk = 0;
   int   n_err = 0;
   frm_t frm_q[$];
   logic [4:0] errq[$];

   channel_event_decoder #(
      .N_CH    (N_CH),
      .TIMEOUT (255)
   ) dut (
      .clk_i         (clk_i),
      .reset_i       (reset_i),
      .arm_i         (arm_i),
      .dump_i        (dump_i),
      .ch_sel_i      (ch_sel_i),
      .frame_ready_i (frame_ready_i),
      .clr_i         (clr_i),
      .frame_o       (frame_o),
      .count_o       (count_o),
      .frame_valid_o (frame_valid_o),
      .err_o         (err_o),
      .err_sticky_o  (err_sticky_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic beat(input logic a, input logic d, input logic [15:0] s);
      arm_i    = a;
      dump_i   = d;
      ch_sel_i = s;
      @(posedge clk_i);
      #1;
      arm_i    = 1'b0;
      dump_i   = 1'b0;
      ch_sel_i = '0;
   endtask

   task automatic idle(input int n);
      repeat (n) beat(1'b0, 1'b0, 16'h0);
   endtask

   task automatic push_frm(input logic [15:0] f, input logic [4:0] c);
      frm_t e;
      e.frame = f;
      e.count = c;
      frm_q.push_back(e);
   endtask

   // Monitor: frames on handshake, every non-zero err_o cycle.
   always @(negedge clk_i) begin
      if (!reset_i) begin
         if (frame_valid_o && frame_ready_i) begin
            if (frm_q.size() == 0) begin
               n_chk++;
               n_err++;
               $display("FAIL frame_unexpected: got frame 0x%0h count %0d, none expected",
                        frame_o, count_o);
            end else begin
               frm_t e;
               e = frm_q.pop_front();
               chk("frame_o", 32'(frame_o), 32'(e.frame));
               chk("count_o", 32'(count_o), 32'(e.count));
            end
         end
         if (err_o != 5'b0) begin
            if (errq.size() == 0) begin
               n_chk++;
               n_err++;
               $display("FAIL err_unexpected: got err_o 0x%0h, none expected", err_o);
            end else begin
               logic [4:0] ee;
               ee = errq.pop_front();
               chk("err_o", 32'(err_o), 32'(ee));
            end
         end
      end
   end

   initial begin
      repeat (3) @(posedge clk_i);
      @(negedge clk_i);
      chk("rst_frame", 32'(frame_o), 32'h0);
      chk("rst_count", 32'(count_o), 32'h0);
      chk("rst_valid", 32'(frame_valid_o), 32'h0);
      chk("rst_err", 32'(err_o), 32'h0);
      chk("rst_sticky", 32'(err_sticky_o), 32'h0);
      @(posedge clk_i);
      #1;
      reset_i = 1'b0;

      // Ordered beats into a clean frame.
      beat(1'b1, 1'b0, 16'h0);
      beat(1'b0, 1'b1, 16'h0002);
      beat(1'b0, 1'b1, 16'h0010);
      beat(1'b0, 1'b1, 16'h8000);
      push_frm(16'h8012, 5'd3);
      beat(1'b0, 1'b1, 16'h0000);
      idle(2);

      // Dump while idle is ignored.
      beat(1'b0, 1'b1, 16'h0004);
      idle(2);

      // Multi-hot beat discarded.
      beat(1'b1, 1'b0, 16'h0);
      errq.push_back(5'b00001);
      beat(1'b0, 1'b1, 16'h0030);
      beat(1'b0, 1'b1, 16'h0004);
      push_frm(16'h0004, 5'd1);
      beat(1'b0, 1'b1, 16'h0000);
      idle(2);

      // Out-of-order and repeated channels.
      beat(1'b1, 1'b0, 16'h0);
      beat(1'b0, 1'b1, 16'h0010);
      errq.push_back(5'b00010);
      beat(1'b0, 1'b1, 16'h0004);
      errq.push_back(5'b00010);
      beat(1'b0, 1'b1, 16'h0004);
      push_frm(16'h0014, 5'd2);
      beat(1'b0, 1'b1, 16'h0000);
      idle(2);

      // Overflow while the slot is held.
      frame_ready_i = 1'b0;
      beat(1'b1, 1'b0, 16'h0);
      beat(1'b0, 1'b1, 16'h0001);
      push_frm(16'h0001, 5'd1);
      beat(1'b0, 1'b1, 16'h0000);
      idle(1);
      beat(1'b1, 1'b0, 16'h0);
      beat(1'b0, 1'b1, 16'h0100);
      errq.push_back(5'b00100);
      beat(1'b0, 1'b1, 16'h0000);
      idle(3);
      @(negedge clk_i);
      chk("held_valid", 32'(frame_valid_o), 32'h1);
      chk("held_frame", 32'(frame_o), 32'h0001);
      frame_ready_i = 1'b1;
      @(posedge clk_i);
      #1;
      @(negedge clk_i);
      chk("valid_drop", 32'(frame_valid_o), 32'h0);

      // Timeout after 255 idle collect cycles.
      @(posedge clk_i);
      #1;
      errq.push_back(5'b10000);
      beat(1'b1, 1'b0, 16'h0);
      idle(257);
      @(negedge clk_i);
      chk("sticky_accum", 32'(err_sticky_o), 32'h17);
      chk("tmo_no_valid", 32'(frame_valid_o), 32'h0);
      beat(1'b1, 1'b0, 16'h0);
      push_frm(16'h0000, 5'd0);
      beat(1'b0, 1'b1, 16'h0000);
      idle(2);

      // 254 idle cycles then terminator: just below the limit.
      beat(1'b1, 1'b0, 16'h0);
      idle(254);
      push_frm(16'h0000, 5'd0);
      beat(1'b0, 1'b1, 16'h0000);
      idle(2);

      // Reset mid-frame.
      beat(1'b1, 1'b0, 16'h0);
      beat(1'b0, 1'b1, 16'h0008);
      reset_i = 1'b1;
      @(posedge clk_i);
      #1;
      reset_i = 1'b0;
      @(negedge clk_i);
      chk("r2_frame", 32'(frame_o), 32'h0);
      chk("r2_count", 32'(count_o), 32'h0);
      chk("r2_valid", 32'(frame_valid_o), 32'h0);
      chk("r2_err", 32'(err_o), 32'h0);
      chk("r2_sticky", 32'(err_sticky_o), 32'h0);

      // Abort, clear collision, then clear.
      beat(1'b1, 1'b0, 16'h0);
      errq.push_back(5'b01000);
      beat(1'b1, 1'b0, 16'h0);
      @(negedge clk_i);
      chk("abort_sticky", 32'(err_sticky_o), 32'h08);
      clr_i = 1'b1;
      errq.push_back(5'b01000);
      beat(1'b1, 1'b0, 16'h0);
      clr_i = 1'b0;
      @(negedge clk_i);
      chk("clr_collide", 32'(err_sticky_o), 32'h08);
      clr_i = 1'b1;
      idle(1);
      clr_i = 1'b0;
      @(negedge clk_i);
      chk("clr_sticky", 32'(err_sticky_o), 32'h0);
      push_frm(16'h0000, 5'd0);
      beat(1'b0, 1'b1, 16'h0000);
      idle(3);

      chk("frames_drained", 32'(frm_q.size()), 32'h0);
      chk("errs_drained", 32'(errq.size()), 32'h0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
